// File: rtl/perf_sched_if.sv
// perf_sched_if: groups the scheduler's host/CSR, layer-controller, perf-monitor
// and readback signals.
//   master modport : the environment (CSR block, layer controller, perf, host reader)
//   slave modport  : perf_sched
// Signals:
//   cfg_arm / cfg_num_layers / cfg_abort      host run control
//   layer_start / layer_done                  layer-boundary pulses
//   perf_start / perf_done                    pulses into perf
//   perf_measurement_done, perf_total/active/idle   perf results
//   rd_idx -> rd_total/active/idle            snapshot readback (1-cycle latency)
//   run_busy, run_done, layers_captured       run status
//   cfg_err, overlap_err, timeout_err         error flags
interface perf_sched_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int IDX_W         = 3
);
  logic                     cfg_arm;
  logic [IDX_W:0]           cfg_num_layers;
  logic                     cfg_abort;
  logic                     layer_start;
  logic                     layer_done;
  logic                     perf_start;
  logic                     perf_done;
  logic                     perf_measurement_done;
  logic [COUNTER_WIDTH-1:0] perf_total;
  logic [COUNTER_WIDTH-1:0] perf_active;
  logic [COUNTER_WIDTH-1:0] perf_idle;
  logic [IDX_W-1:0]         rd_idx;
  logic [COUNTER_WIDTH-1:0] rd_total;
  logic [COUNTER_WIDTH-1:0] rd_active;
  logic [COUNTER_WIDTH-1:0] rd_idle;
  logic                     run_busy;
  logic                     run_done;
  logic [IDX_W:0]           layers_captured;
  logic                     cfg_err;
  logic                     overlap_err;
  logic                     timeout_err;

  modport master (
    output cfg_arm, cfg_num_layers, cfg_abort, layer_start, layer_done,
           perf_measurement_done, perf_total, perf_active, perf_idle, rd_idx,
    input  perf_start, perf_done, rd_total, rd_active, rd_idle, run_busy,
           run_done, layers_captured, cfg_err, overlap_err, timeout_err
  );

  modport slave (
    input  cfg_arm, cfg_num_layers, cfg_abort, layer_start, layer_done,
           perf_measurement_done, perf_total, perf_active, perf_idle, rd_idx,
    output perf_start, perf_done, rd_total, rd_active, rd_idle, run_busy,
           run_done, layers_captured, cfg_err, overlap_err, timeout_err
  );
endinterface

// File: rtl/perf_sched.sv
// perf_sched: per-layer measurement scheduler for the perf monitor.
// Sequences perf start/done pulses from layer boundaries over a host-armed run
// of up to MAX_LAYERS layers and captures perf total/active/idle into a
// per-layer snapshot bank after each layer. The bank is read back through
// rd_idx with one cycle of latency.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset (also clears the snapshot bank)
//   bus    perf_sched_if.slave, see the interface file for the signal list
module perf_sched #(
  parameter int COUNTER_WIDTH = 32,
  parameter int MAX_LAYERS    = 8,
  parameter int IDX_W         = 3,
  parameter int CAP_TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  perf_sched_if.slave  bus
);

  localparam int TMO_W = $clog2(CAP_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_MEASURE  = 2'd2;
  localparam logic [1:0] S_WAIT_CAP = 2'd3;

  logic [1:0]       state;
  logic [IDX_W:0]   num_layers;
  logic [IDX_W:0]   layer_cnt;
  logic [IDX_W:0]   layers_captured;
  logic             pend_done;
  logic [TMO_W-1:0] tmo_cnt;
  logic             perf_start_q;
  logic             perf_done_q;
  logic             run_done_q;
  logic             cfg_err_q;
  logic             overlap_err_q;
  logic             timeout_err_q;

  logic [COUNTER_WIDTH-1:0] bank_total  [MAX_LAYERS];
  logic [COUNTER_WIDTH-1:0] bank_active [MAX_LAYERS];
  logic [COUNTER_WIDTH-1:0] bank_idle   [MAX_LAYERS];
  logic [COUNTER_WIDTH-1:0] rd_total_q;
  logic [COUNTER_WIDTH-1:0] rd_active_q;
  logic [COUNTER_WIDTH-1:0] rd_idle_q;

  logic num_valid;
  logic capture;
  logic last_layer;

  assign num_valid  = (bus.cfg_num_layers != '0) &&
                      (bus.cfg_num_layers <= (IDX_W+1)'(MAX_LAYERS));
  // Abort takes priority, so a capture never happens in an aborting cycle.
  assign capture    = (state == S_WAIT_CAP) && !bus.cfg_abort &&
                      (bus.perf_measurement_done || (tmo_cnt == '0));
  assign last_layer = ((layer_cnt + (IDX_W+1)'(1)) == num_layers);

  // Control FSM, pulse outputs and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      num_layers      <= '0;
      layer_cnt       <= '0;
      layers_captured <= '0;
      pend_done       <= 1'b0;
      tmo_cnt         <= '0;
      perf_start_q    <= 1'b0;
      perf_done_q     <= 1'b0;
      run_done_q      <= 1'b0;
      cfg_err_q       <= 1'b0;
      overlap_err_q   <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the pre-edge values; the defaults make the pulses one cycle wide.
      perf_start_q <= 1'b0;
      perf_done_q  <= 1'b0;
      run_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;

      if (bus.cfg_abort) begin
        // Close the open perf window so perf is not left measuring.
        if (state == S_MEASURE) perf_done_q <= 1'b1;
        state     <= S_IDLE;
        pend_done <= 1'b0;
      end else begin
        if (bus.cfg_arm && (state != S_IDLE)) cfg_err_q <= 1'b1;

        case (state)
          S_IDLE: begin
            if (bus.cfg_arm) begin
              if (num_valid) begin
                state           <= S_ARMED;
                num_layers      <= bus.cfg_num_layers;
                layer_cnt       <= '0;
                layers_captured <= '0;
                overlap_err_q   <= 1'b0;
                timeout_err_q   <= 1'b0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end

          S_ARMED: begin
            if (bus.layer_start) begin
              perf_start_q <= 1'b1;
              // A zero-length layer: remember the done for MEASURE's first cycle.
              pend_done    <= bus.layer_done;
              state        <= S_MEASURE;
            end else if (bus.layer_done) begin
              overlap_err_q <= 1'b1;
            end
          end

          S_MEASURE: begin
            if (bus.layer_start) overlap_err_q <= 1'b1;
            if (bus.layer_done || pend_done) begin
              perf_done_q <= 1'b1;
              pend_done   <= 1'b0;
              tmo_cnt     <= TMO_W'(CAP_TIMEOUT);
              state       <= S_WAIT_CAP;
            end
          end

          S_WAIT_CAP: begin
            if (capture) begin
              layer_cnt       <= layer_cnt + (IDX_W+1)'(1);
              layers_captured <= layers_captured + (IDX_W+1)'(1);
              if (!bus.perf_measurement_done) timeout_err_q <= 1'b1;
              if (last_layer) begin
                run_done_q <= 1'b1;
                state      <= S_IDLE;
              end else begin
                state <= S_ARMED;
              end
            end else begin
              tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Snapshot bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bank is deliberately reset (reads after reset must return 0),
      // which forces flops rather than a RAM macro; fine at this depth.
      for (int i = 0; i < MAX_LAYERS; i++) begin
        bank_total[i]  <= '0;
        bank_active[i] <= '0;
        bank_idle[i]   <= '0;
      end
    end else if (capture) begin
      bank_total[layer_cnt[IDX_W-1:0]]  <= bus.perf_total;
      bank_active[layer_cnt[IDX_W-1:0]] <= bus.perf_active;
      bank_idle[layer_cnt[IDX_W-1:0]]   <= bus.perf_idle;
    end
  end

  // Registered readback, refreshed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_total_q  <= '0;
      rd_active_q <= '0;
      rd_idle_q   <= '0;
    end else begin
      rd_total_q  <= bank_total[bus.rd_idx];
      rd_active_q <= bank_active[bus.rd_idx];
      rd_idle_q   <= bank_idle[bus.rd_idx];
    end
  end

  assign bus.perf_start      = perf_start_q;
  assign bus.perf_done       = perf_done_q;
  assign bus.run_done        = run_done_q;
  assign bus.cfg_err         = cfg_err_q;
  assign bus.overlap_err     = overlap_err_q;
  assign bus.timeout_err     = timeout_err_q;
  assign bus.run_busy        = (state != S_IDLE);
  assign bus.layers_captured = layers_captured;
  assign bus.rd_total        = rd_total_q;
  assign bus.rd_active       = rd_active_q;
  assign bus.rd_idle         = rd_idle_q;

endmodule

// File: tb/tb_perf_sched.sv
// tb_perf_sched: scoreboard bench for perf_sched. Stimulus tasks push the
// cycle at which each pulse output must appear; a negedge monitor pops and
// compares. Captures, sticky flags and bank contents are predicted by a
// transaction-level model (per-run layer count, captured count, bank arrays).
module tb_perf_sched;
  localparam int CW = 32;
  localparam int ML = 8;
  localparam int IW = 3;
  localparam int CT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  perf_sched_if #(.COUNTER_WIDTH(CW), .IDX_W(IW)) bus ();

  perf_sched #(.COUNTER_WIDTH(CW), .MAX_LAYERS(ML), .IDX_W(IW), .CAP_TIMEOUT(CT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected pulse cycles.
  int exp_start[$];
  int exp_done[$];
  int exp_rdone[$];
  int exp_cerr[$];

  // Reference model.
  bit          m_busy;
  bit          m_measuring;
  int          m_num;
  int          m_cap;
  bit          m_ovl;
  bit          m_tmo;
  logic [CW-1:0] m_tot [ML];
  logic [CW-1:0] m_act [ML];
  logic [CW-1:0] m_idl [ML];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_start.size() > 0 && exp_start[0] == cyc) begin
        check("perf_start_pulse", bus.perf_start, 1);
        void'(exp_start.pop_front());
      end else if (bus.perf_start) check("perf_start_spurious", bus.perf_start, 0);

      if (exp_done.size() > 0 && exp_done[0] == cyc) begin
        check("perf_done_pulse", bus.perf_done, 1);
        void'(exp_done.pop_front());
      end else if (bus.perf_done) check("perf_done_spurious", bus.perf_done, 0);

      if (exp_rdone.size() > 0 && exp_rdone[0] == cyc) begin
        check("run_done_pulse", bus.run_done, 1);
        void'(exp_rdone.pop_front());
      end else if (bus.run_done) check("run_done_spurious", bus.run_done, 0);

      if (exp_cerr.size() > 0 && exp_cerr[0] == cyc) begin
        check("cfg_err_pulse", bus.cfg_err, 1);
        void'(exp_cerr.pop_front());
      end else if (bus.cfg_err) check("cfg_err_spurious", bus.cfg_err, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    bus.cfg_arm               = 1'b0;
    bus.cfg_abort             = 1'b0;
    bus.layer_start           = 1'b0;
    bus.layer_done            = 1'b0;
    bus.perf_measurement_done = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_measuring = 0; m_num = 0; m_cap = 0; m_ovl = 0; m_tmo = 0;
    for (int i = 0; i < ML; i++) begin
      m_tot[i] = '0; m_act[i] = '0; m_idl[i] = '0;
    end
    exp_start.delete(); exp_done.delete(); exp_rdone.delete(); exp_cerr.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, bus.run_busy, m_busy);
    check({tag, "_captured"}, bus.layers_captured, m_cap);
    check({tag, "_overlap_err"}, bus.overlap_err, m_ovl);
    check({tag, "_timeout_err"}, bus.timeout_err, m_tmo);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_perf_start"}, bus.perf_start, 0);
    check({tag, "_perf_done"}, bus.perf_done, 0);
    check({tag, "_run_done"}, bus.run_done, 0);
    check({tag, "_cfg_err"}, bus.cfg_err, 0);
    check({tag, "_rd_total"}, bus.rd_total, 0);
    check({tag, "_rd_active"}, bus.rd_active, 0);
    check({tag, "_rd_idle"}, bus.rd_idle, 0);
    check_status(tag);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < ML; i++) begin
      bus.rd_idx = IW'(i);
      tick();
      check({tag, "_rd_total"}, bus.rd_total, m_tot[i]);
      check({tag, "_rd_active"}, bus.rd_active, m_act[i]);
      check({tag, "_rd_idle"}, bus.rd_idle, m_idl[i]);
    end
  endtask

  // Arm request; with_abort drives cfg_abort in the same cycle.
  task automatic do_arm(input int n, input bit with_abort);
    bus.cfg_arm        = 1'b1;
    bus.cfg_num_layers = (IW+1)'(n);
    bus.cfg_abort      = with_abort;
    if (with_abort) begin
      if (m_measuring) exp_done.push_back(cyc + 1);
      m_busy = 0; m_measuring = 0;
    end else if (m_busy || n < 1 || n > ML) begin
      exp_cerr.push_back(cyc + 1);
    end else begin
      m_busy = 1; m_num = n; m_cap = 0; m_ovl = 0; m_tmo = 0;
    end
    tick();
    clr_pulses();
    check_status("arm");
  endtask

  // Start a layer and bring it to the perf_done cycle.
  task automatic open_layer(input int len, input bit ovl);
    if (len == 0) begin
      bus.layer_start = 1'b1;
      bus.layer_done  = 1'b1;
      exp_start.push_back(cyc + 1);
      exp_done.push_back(cyc + 2);
      tick();
      clr_pulses();
      tick();
    end else begin
      bus.layer_start = 1'b1;
      exp_start.push_back(cyc + 1);
      m_measuring = 1;
      tick();
      clr_pulses();
      for (int k = 0; k < len; k++) begin
        if (ovl && k == 0) begin
          bus.layer_start = 1'b1;
          m_ovl = 1;
        end
        tick();
        clr_pulses();
      end
      bus.layer_done = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      clr_pulses();
    end
    m_measuring = 0;
  endtask

  // One full layer; returns at the cycle the capture is visible.
  task automatic run_layer(input int len, input bit ovl, input bit tmo, input int md_delay,
                           input logic [CW-1:0] t, input logic [CW-1:0] a,
                           input logic [CW-1:0] i);
    bit last;
    open_layer(len, ovl);
    last = (m_cap + 1 == m_num);
    bus.perf_total = t; bus.perf_active = a; bus.perf_idle = i;
    if (tmo) begin
      if (last) exp_rdone.push_back(cyc + CT + 1);
      repeat (CT) tick();
      check("tmo_no_early_capture", bus.layers_captured, m_cap);
      tick();
      m_tmo = 1;
    end else begin
      repeat (md_delay) tick();
      bus.perf_measurement_done = 1'b1;
      if (last) exp_rdone.push_back(cyc + 1);
      tick();
      clr_pulses();
    end
    m_tot[m_cap] = t; m_act[m_cap] = a; m_idl[m_cap] = i;
    m_cap++;
    if (last) m_busy = 0;
    // Scramble perf outputs so any late second capture would be visible.
    bus.perf_total = $urandom; bus.perf_active = $urandom; bus.perf_idle = $urandom;
    check_status("capture");
  endtask

  initial begin
    clr_pulses();
    bus.cfg_num_layers = '0;
    bus.perf_total = '0; bus.perf_active = '0; bus.perf_idle = '0;
    bus.rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Two-layer run with fixed counter values.
    do_arm(2, 0);
    run_layer(6, 0, 0, 2, 32'd10, 32'd6, 32'd4);
    run_layer(6, 0, 0, 1, 32'd20, 32'd20, 32'd0);
    check_bank("two_layer");

    // Arm rejection: zero, too many, while armed.
    do_arm(0, 0);
    do_arm(9, 0);
    do_arm(2, 0);
    do_arm(3, 0);
    // Done without start while ARMED is an overlap.
    bus.layer_done = 1'b1;
    m_ovl = 1;
    tick();
    clr_pulses();
    check_status("armed_stray_done");
    // Overlap start in MEASURE, then a zero-length layer.
    run_layer(4, 1, 0, 0, 32'h1111, 32'h0aaa, 32'h0667);
    run_layer(0, 0, 0, 3, 32'h2222, 32'h2000, 32'h0222);

    // Timeout capture on a single-layer run.
    do_arm(1, 0);
    run_layer(3, 0, 1, 0, 32'hdead_beef, 32'h1234_5678, 32'h0bad_f00d);
    check_bank("timeout");

    // Abort during MEASURE of layer 2 of 3.
    do_arm(3, 0);
    run_layer(2, 1, 0, 0, 32'h0000_0100, 32'h0000_00c0, 32'h0000_0040);
    bus.layer_start = 1'b1;
    exp_start.push_back(cyc + 1);
    m_measuring = 1;
    tick();
    clr_pulses();
    tick();
    bus.cfg_abort = 1'b1;
    exp_done.push_back(cyc + 1);
    m_busy = 0; m_measuring = 0;
    tick();
    clr_pulses();
    check_status("abort");
    check_bank("abort");
    // Arm+abort in the same cycle is dropped without cfg_err.
    do_arm(2, 0);
    do_arm(2, 1);
    do_arm(1, 0);
    run_layer(1, 0, 0, 0, 32'h55, 32'h44, 32'h11);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) do_arm(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15), 0);
      do_arm($urandom_range(1, 4), 0);
      for (int l = 0; l < m_num; l++) begin
        int len;
        len = $urandom_range(0, 5);
        run_layer(len, (len > 0) && ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 6),
                  $urandom, $urandom, $urandom);
      end
      check_bank("random");
    end

    // Asynchronous reset mid-MEASURE.
    do_arm(2, 0);
    bus.layer_start = 1'b1;
    exp_start.push_back(cyc + 1);
    tick();
    clr_pulses();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check_bank("after_reset");
    do_arm(1, 0);
    run_layer(2, 0, 0, 1, 32'h77, 32'h70, 32'h07);
    check_bank("after_reset_run");

    repeat (3) tick();
    check("pending_perf_start", exp_start.size(), 0);
    check("pending_perf_done", exp_done.size(), 0);
    check("pending_run_done", exp_rdone.size(), 0);
    check("pending_cfg_err", exp_cerr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_sched.md
# perf_sched

Per-layer measurement scheduler for the `perf` monitor. It sequences `perf` start/done pulses from the accelerator's layer boundaries over a host-armed run of up to `MAX_LAYERS` layers. After each layer it captures the `perf` total/active/idle counters into a per-layer snapshot bank, which the host reads back through an indexed port. It sits between the layer controller, the CSR block and `perf`.

## Interface
- `COUNTER_WIDTH`, 32, width of the `perf` counters and the snapshot entries.
- `MAX_LAYERS`, 8, number of snapshot bank entries (power of 2).
- `IDX_W`, 3, log2(`MAX_LAYERS`).
- `CAP_TIMEOUT`, 16, cycles to wait for `perf_measurement_done` before a forced capture.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_arm`  in  1  pulse; arm a run.
- `cfg_num_layers`  in  IDX_W+1  layers in the run; valid range 1..MAX_LAYERS.
- `cfg_abort`  in  1  pulse; terminate the run.
- `layer_start`  in  1  pulse from the layer controller.
- `layer_done`  in  1  pulse from the layer controller.
- `perf_start`  out  1  drives `perf.start_pulse`.
- `perf_done`  out  1  drives `perf.done_pulse`.
- `perf_measurement_done`  in  1  from `perf`.
- `perf_total`, `perf_active`, `perf_idle`  in  COUNTER_WIDTH each  `perf` counter outputs.
- `rd_idx`  in  IDX_W  snapshot read index.
- `rd_total`, `rd_active`, `rd_idle`  out  COUNTER_WIDTH each  registered snapshot read data.
- `run_busy`  out  1  high when the state is not IDLE.
- `run_done`  out  1  one-cycle pulse when the last layer is captured.
- `layers_captured`  out  IDX_W+1  snapshots written in the current or last run.
- `cfg_err`  out  1  one-cycle pulse when an arm is rejected.
- `overlap_err`  out  1  sticky; cleared by the next accepted arm.
- `timeout_err`  out  1  sticky; cleared by the next accepted arm.

## Operation
- **States:** IDLE, ARMED, MEASURE, WAIT_CAP.
- **IDLE**
  - `cfg_arm` with `cfg_num_layers` in 1..MAX_LAYERS: go to ARMED. Latch `num_layers`; clear `layer_cnt`, `layers_captured`, `overlap_err` and `timeout_err`.
  - Invalid `cfg_num_layers` (0 or >MAX_LAYERS): pulse `cfg_err`, stay in IDLE.
  - `layer_start` and `layer_done` are ignored.
- **ARMED**
  - `layer_start`: pulse `perf_start`, go to MEASURE.
  - `layer_done` without `layer_start`: ignored, and `overlap_err` is set.
  - `layer_start` and `layer_done` in the same cycle: start is taken and a `pend_done` flag is set. MEASURE then acts on it in its first cycle.
- **MEASURE**
  - `layer_done` or `pend_done`: pulse `perf_done`, clear `pend_done`, load the timeout counter with CAP_TIMEOUT, go to WAIT_CAP.
  - `layer_start`: set `overlap_err`; the pulse is otherwise ignored.
- **WAIT_CAP**
  - `perf_measurement_done`, or the timeout counter reaching 0: write `perf_total`/`perf_active`/`perf_idle` into bank[`layer_cnt`] and increment `layer_cnt` and `layers_captured`.
  - A timeout capture additionally sets `timeout_err`.
  - If this was the last layer (`layer_cnt`+1 == `num_layers`): pulse `run_done`, go to IDLE. Otherwise go to ARMED.
- **Abort**
  - `cfg_abort` in any state forces IDLE next cycle. If the block is in MEASURE, `perf_done` is pulsed in the same cycle as the transition so that `perf` is closed.
  - No capture, no `run_done`; the bank and `layers_captured` are retained.
  - `cfg_abort` and `cfg_arm` in the same cycle: abort wins, arm is dropped with no `cfg_err`.
- **Arm while busy:** `cfg_arm` when not in IDLE is ignored and pulses `cfg_err`.
- **Readback:** `rd_*` registered from bank[`rd_idx`] every cycle. Reads are legal at any time; an entry written in cycle N is readable from cycle N+1.
- **Width:** counters are stored verbatim with no arithmetic. The timeout counter is $clog2(CAP_TIMEOUT+1) bits wide.

## Timing
- **Reset:** all outputs 0, state IDLE, bank entries 0, `pend_done` 0.
- **Registered pulses:** `perf_start`, `perf_done`, `run_done` and `cfg_err` are one cycle wide. Each is asserted in the cycle after the triggering input is sampled.
- **Zero-length layer:** `layer_start` and `layer_done` in the same cycle give `perf_start` at cycle +1 and `perf_done` at cycle +2.
- **Capture:** the bank write happens on the edge that samples `perf_measurement_done`. `layers_captured` updates on the same edge.
- **Timeout:** capture occurs CAP_TIMEOUT+1 cycles after `perf_done` if `perf_measurement_done` never arrives.
- **Readback latency:** 1 cycle from `rd_idx` to `rd_*`.
- **Reset mid-run:** immediate return to IDLE with the bank cleared. `perf` is expected to be reset by the same `rst_n`.

## Test plan
- **Two-layer run:** arm with `num_layers`=2. Per layer: `layer_start`, 6 cycles, `layer_done`, then `perf` returns measurement_done with total=10/active=6/idle=4, then 20/20/0.
  - Expect `run_done` once, `layers_captured`=2.
  - `rd_idx`=0 reads 10/6/4; `rd_idx`=1 reads 20/20/0.
- **Arm rejection:**
  - arm with `num_layers`=0 gives a `cfg_err` pulse and `run_busy` stays 0.
  - arm with 9 gives `cfg_err`.
  - arm while ARMED gives `cfg_err` and the state is unchanged.
- **Overlap:**
  - `layer_start` during MEASURE sets `overlap_err`=1 with no extra `perf_start`.
  - same-cycle start+done gives `perf_start` at +1 and `perf_done` at +2.
- **Timeout:** hold `perf_measurement_done` low after `perf_done`. Expect a capture 17 cycles later, `timeout_err`=1, and bank[0] equal to the `perf_*` inputs at that edge.
- **Abort:** abort in MEASURE of layer 2 of 3.
  - Expect a `perf_done` pulse, IDLE next cycle, `layers_captured`=1, no `run_done`, bank[0] intact.
  - A following arm clears the sticky errors.
- **Async reset:** drop `rst_n` mid-MEASURE.
  - All outputs go to 0 immediately and bank reads return 0.
  - After release, a 1-layer run completes normally.
